// File: rtl/bcd_display_scan.sv
// Scans a 3-digit BCD value onto a multiplexed 7-segment display with a
// programmable per-digit dwell, anti-ghost blanking and frame-aligned updates.
//
// state | meaning
// ------+---------------------------------------------
// S_U   | units digit dwell (dig[0])
// S_T   | tens digit dwell (dig[1])
// S_H   | hundreds digit dwell (dig[2]); wrap = frame end
module bcd_display_scan #(
  parameter int DIV_WIDTH = 16,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ld,
  input  logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  dig,
  output logic        frame
);

  typedef enum logic [1:0] {
    S_U = 2'd0,
    S_T = 2'd1,
    S_H = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_LAST  = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [DIV_WIDTH:0]   BLANK_LIM = (DIV_WIDTH + 1)'(BLANK_CYC);

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [11:0]          shadow;
  logic [11:0]          pending;
  logic                 pend_flag;

  logic                 advance;
  logic                 boundary;
  logic                 in_blank;
  logic                 lz_blank;
  logic [3:0]           nib;
  logic [2:0]           dig_sel;
  logic [6:0]           seg_dec;
  state_t               state_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    advance   = en && (cnt == CNT_LAST);
    boundary  = advance && (state == S_H);
    in_blank  = ({1'b0, cnt} < BLANK_LIM);
    nib       = 4'd0;
    lz_blank  = 1'b0;
    dig_sel   = 3'b000;
    state_nxt = S_U;
    case (state)
      S_U: begin
        nib       = shadow[3:0];
        dig_sel   = 3'b001;
        state_nxt = S_T;
      end
      S_T: begin
        nib       = shadow[7:4];
        lz_blank  = (shadow[11:4] == 8'h00);
        dig_sel   = 3'b010;
        state_nxt = S_H;
      end
      S_H: begin
        nib       = shadow[11:8];
        lz_blank  = (shadow[11:8] == 4'h0);
        dig_sel   = 3'b100;
        state_nxt = S_U;
      end
      default: begin
        nib       = 4'd0;
        lz_blank  = 1'b0;
        dig_sel   = 3'b000;
        state_nxt = S_U;
      end
    endcase
    seg_dec = lz_blank ? 7'h00 : seg_decode(nib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_U;
      cnt       <= '0;
      shadow    <= 12'h000;
      pending   <= 12'h000;
      pend_flag <= 1'b0;
      seg       <= 7'h00;
      dig       <= 3'b000;
      frame     <= 1'b0;
    end else begin
      if (en) begin
        if (advance) begin
          cnt   <= '0;
          state <= state_nxt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // A strobe landing on the wrap cycle bypasses the pending buffer.
      if (ld) begin
        if (boundary) begin
          shadow    <= bcd;
          pending   <= bcd;
          pend_flag <= 1'b0;
        end else begin
          pending   <= bcd;
          pend_flag <= 1'b1;
        end
      end else if (boundary && pend_flag) begin
        shadow    <= pending;
        pend_flag <= 1'b0;
      end

      if (!en || in_blank) begin
        seg <= 7'h00;
        dig <= 3'b000;
      end else begin
        seg <= seg_dec;
        dig <= dig_sel;
      end
      frame <= boundary;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan (SCAN_DIV=4, BLANK_CYC=1): a frame
// position model feeds a scoreboard queue, plus fixed spot checks per scenario.
`timescale 1ns/1ps
module tb_bcd_display_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ld;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  dig;
  logic        frame;

  int n_checks = 0;
  int n_pass   = 0;

  logic [10:0] sb[$];

  int          m_pos;
  logic [11:0] m_shadow;
  logic [11:0] m_pend;
  logic        m_pflag;

  bcd_display_scan #(
    .DIV_WIDTH(16),
    .SCAN_DIV (4),
    .BLANK_CYC(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .ld   (ld),
    .bcd  (bcd),
    .seg  (seg),
    .dig  (dig),
    .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic m_reset();
    m_pos    = 0;
    m_shadow = 12'h000;
    m_pend   = 12'h000;
    m_pflag  = 1'b0;
  endtask

  // Position 0..11 in a frame: digit = pos/4, dwell cycle = pos%4.
  function automatic logic [10:0] m_out(input logic e);
    int          c;
    int          d;
    logic [3:0]  n;
    logic        blk;
    logic [6:0]  s;
    logic [2:0]  dg;
    logic        fr;
    if (!e) return 11'h000;
    c  = m_pos % 4;
    d  = m_pos / 4;
    fr = (m_pos == 11);
    if (c < 1) return {fr, 3'b000, 7'h00};
    n   = m_shadow[d*4 +: 4];
    blk = (d == 2 && m_shadow[11:8] == 4'h0) || (d == 1 && m_shadow[11:4] == 8'h00);
    s   = blk ? 7'h00 : dec7(n);
    dg  = 3'(1 << d);
    return {fr, dg, s};
  endfunction

  task automatic m_adv(input logic e, input logic l, input logic [11:0] b);
    logic bnd;
    bnd = e && (m_pos == 11);
    if (e) m_pos = (m_pos + 1) % 12;
    if (l) begin
      if (bnd) begin
        m_shadow = b;
        m_pflag  = 1'b0;
      end else begin
        m_pend  = b;
        m_pflag = 1'b1;
      end
    end else if (bnd && m_pflag) begin
      m_shadow = m_pend;
      m_pflag  = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the following negedge with outputs settled.
  task automatic step(input logic e, input logic l, input logic [11:0] b);
    logic [10:0] exp_v;
    en  = e;
    ld  = l;
    bcd = b;
    exp_v = m_out(e);
    m_adv(e, l, b);
    sb.push_back(exp_v);
    @(negedge clk);
    chk("scan_out", 32'({frame, dig, seg}), 32'(sb.pop_front()));
  endtask

  task automatic run_frame(input int ld_pos, input logic [11:0] v,
                           output logic [6:0] su, output logic [6:0] st,
                           output logic [6:0] sh);
    su = 7'h00;
    st = 7'h00;
    sh = 7'h00;
    for (int p = 0; p < 12; p++) begin
      step(1'b1, p == ld_pos, v);
      if (p == 1) su = seg;
      if (p == 5) st = seg;
      if (p == 9) sh = seg;
    end
  endtask

  task automatic chk_digits(input string tag, input logic [6:0] su, input logic [6:0] st,
                            input logic [6:0] sh, input logic [6:0] eu,
                            input logic [6:0] et, input logic [6:0] eh);
    chk({tag, "_units"},    32'(su), 32'(eu));
    chk({tag, "_tens"},     32'(st), 32'(et));
    chk({tag, "_hundreds"}, 32'(sh), 32'(eh));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] su, st, sh;
    rst = 1'b0;
    en  = 1'b0;
    ld  = 1'b0;
    bcd = 12'h000;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_seg",   32'(seg),   32'h00);
    chk("reset_dig",   32'(dig),   32'h0);
    chk("reset_frame", 32'(frame), 32'h0);
    rst = 1'b1;

    // Scenario 1: load 255 at the start; first frame shows 0, second 255.
    for (int i = 0; i < 24; i++) begin
      step(1'b1, i == 0, 12'h255);
      case (i)
        0:  chk("s1_blank_dig", 32'(dig), 32'h0);
        1:  begin chk("s1_f1_u_seg", 32'(seg), 32'h3F); chk("s1_f1_u_dig", 32'(dig), 32'h1); end
        5:  begin chk("s1_f1_t_seg", 32'(seg), 32'h00); chk("s1_f1_t_dig", 32'(dig), 32'h2); end
        9:  begin chk("s1_f1_h_seg", 32'(seg), 32'h00); chk("s1_f1_h_dig", 32'(dig), 32'h4); end
        10: chk("s1_no_frame", 32'(frame), 32'h0);
        11: chk("s1_frame1", 32'(frame), 32'h1);
        12: chk("s1_f2_blank_dig", 32'(dig), 32'h0);
        13: begin chk("s1_f2_u_seg", 32'(seg), 32'h6D); chk("s1_f2_u_dig", 32'(dig), 32'h1); end
        17: begin chk("s1_f2_t_seg", 32'(seg), 32'h6D); chk("s1_f2_t_dig", 32'(dig), 32'h2); end
        21: begin chk("s1_f2_h_seg", 32'(seg), 32'h5B); chk("s1_f2_h_dig", 32'(dig), 32'h4); end
        23: chk("s1_frame2", 32'(frame), 32'h1);
        default: ;
      endcase
    end

    // Scenario 2: leading-zero blanking.
    run_frame(0, 12'h007, su, st, sh);
    run_frame(0, 12'h100, su, st, sh);
    chk_digits("s2_007", su, st, sh, 7'h07, 7'h00, 7'h00);
    run_frame(0, 12'h000, su, st, sh);
    chk_digits("s2_100", su, st, sh, 7'h3F, 7'h3F, 7'h06);
    run_frame(0, 12'h255, su, st, sh);
    chk_digits("s2_000", su, st, sh, 7'h3F, 7'h00, 7'h00);

    // Scenario 3: update mid-frame (during S_T) must not tear.
    run_frame(5, 12'h123, su, st, sh);
    chk_digits("s3_cur", su, st, sh, 7'h6D, 7'h6D, 7'h5B);
    run_frame(0, 12'h0A0, su, st, sh);
    chk_digits("s3_next", su, st, sh, 7'h4F, 7'h5B, 7'h06);

    // Scenario 4: invalid tens nibble.
    run_frame(-1, 12'h000, su, st, sh);
    chk_digits("s4_0a0", su, st, sh, 7'h3F, 7'h40, 7'h00);

    // Scenario 5: enable dropped at S_T cnt=2; ld while disabled still lands.
    for (int p = 0; p < 6; p++) step(1'b1, 1'b0, 12'h000);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, k == 2, 12'h042);
      chk("s5_off_dig",   32'(dig),   32'h0);
      chk("s5_off_seg",   32'(seg),   32'h00);
      chk("s5_off_frame", 32'(frame), 32'h0);
    end
    step(1'b1, 1'b0, 12'h000);
    chk("s5_resume_dig0", 32'(dig), 32'h2);
    chk("s5_resume_seg0", 32'(seg), 32'h40);
    step(1'b1, 1'b0, 12'h000);
    chk("s5_resume_dig1", 32'(dig), 32'h2);
    step(1'b1, 1'b0, 12'h000);
    chk("s5_h_blank_dig", 32'(dig), 32'h0);
    step(1'b1, 1'b0, 12'h000);
    chk("s5_h_dig", 32'(dig), 32'h4);
    step(1'b1, 1'b0, 12'h000);
    step(1'b1, 1'b0, 12'h000);
    chk("s5_frame", 32'(frame), 32'h1);
    run_frame(-1, 12'h000, su, st, sh);
    chk_digits("s5_042", su, st, sh, 7'h5B, 7'h66, 7'h00);

    // Scenario 6: async reset in the middle of S_H discards pending/shadow.
    for (int p = 0; p < 10; p++) step(1'b1, p == 0, 12'h777);
    chk("s6_pre_dig", 32'(dig), 32'h4);
    #2;
    rst = 1'b0;
    #1;
    chk("s6_async_seg",   32'(seg),   32'h00);
    chk("s6_async_dig",   32'(dig),   32'h0);
    chk("s6_async_frame", 32'(frame), 32'h0);
    @(negedge clk);
    chk("s6_held_frame", 32'(frame), 32'h0);
    chk("s6_held_dig",   32'(dig),   32'h0);
    rst = 1'b1;
    m_reset();
    run_frame(-1, 12'h000, su, st, sh);
    chk_digits("s6_f1", su, st, sh, 7'h3F, 7'h00, 7'h00);
    run_frame(-1, 12'h000, su, st, sh);
    chk_digits("s6_f2", su, st, sh, 7'h3F, 7'h00, 7'h00);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
